lm_sm_sequencer: RTL
====================

Name: lm_sm_sequencer

Overview:
- Decode-stage sequencer for Load Multiple (LM) and Store Multiple (SM) instructions in the 6-stage pipeline.
- Expands the 8-bit register mask into one micro-op per set bit. Each micro-op carries the register index (LM_reg) and a word address.
- LM_reg feeds the destination-register select mux at write-back for LM, and the register-file read port for SM.
- Holds fetch/decode with stall until the final micro-op issues.

Parameters:
- ADDR_W, 16, width of base and generated memory address.
- ADDR_STEP, 1, address increment per transfer (word-addressed memory).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  decode presents a valid LM/SM this cycle.
- is_store  input  1  1 = SM, 0 = LM; sampled with start.
- imm8  input  8  register mask; bit i selects Ri.
- base_addr  input  ADDR_W  start address (contents of RA); sampled with start.
- flush  input  1  pipeline flush from branch/jump resolution.
- valid  output  1  micro-op outputs valid this cycle.
- LM_reg  output  3  register index of current micro-op.
- mem_addr  output  ADDR_W  memory address of current micro-op.
- is_store_o  output  1  latched is_store for current micro-op.
- last  output  1  current micro-op is the final one of the instruction.
- stall  output  1  hold PC/IF/ID registers this cycle.
- busy  output  1  sequencer in RUN state.

Behaviour:
- States: IDLE, RUN. Reset (rst_n=0 at a clock edge) forces IDLE.
- Reset values: valid=0, LM_reg=0, mem_addr=0, is_store_o=0, last=0, busy=0, mask register=0, address register=0.
- All outputs except stall are registered. stall is combinational.
- IDLE, start=1, imm8!=0, flush=0:
  - Latch is_store and the mask with its lowest set bit cleared.
  - Next cycle: RUN, valid=1, LM_reg = index of lowest set bit of imm8, mem_addr=base_addr.
  - last=1 if imm8 has exactly one bit set.
- IDLE, start=1, imm8==0: treated as NOP. Stays IDLE, valid stays 0, stall stays 0.
- RUN, each cycle with last=0 and flush=0:
  - Next LM_reg = lowest set bit of the remaining mask; clear that bit.
  - mem_addr += ADDR_STEP.
  - last=1 when the remaining mask after clearing is zero.
- RUN with last=1: next cycle IDLE, valid=0, last=0. A start in that same cycle is accepted as in IDLE (back-to-back issue, no bubble).
- Order: ascending register index (R0 first). Transfer count = popcount(imm8), 1..8 cycles. Latency start -> first valid = 1 cycle.
- Address arithmetic is modulo 2^ADDR_W and wraps silently (0xFFFF+1 -> 0x0000).
- stall = (IDLE or (RUN and last)) and start and popcount(imm8)>1, OR (RUN and !last). The final micro-op cycle does not stall unless a new multi-bit start arrives.
- start while RUN and last=0 is ignored; upstream is held by stall.
- flush=1 (any state): next cycle IDLE, valid=0, last=0, mask cleared. flush takes priority over start and over sequencing. stall is forced 0 in the flush cycle.
- rst_n=0 mid-sequence: same effect as flush plus all outputs to reset values. Reset takes priority over flush.
- LM_reg and mem_addr hold their last values while valid=0. Consumers must qualify with valid.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with start=1, imm8=FF -> all outputs 0, busy=0, stall=0.
- LM: start, is_store=0, imm8=8'b1010_0100, base_addr=0x0040 -> valid on 3 consecutive cycles, (LM_reg, mem_addr) = (2,0x40), (5,0x41), (7,0x42); last only on the third; stall high on the start cycle and the first two RUN cycles, low on the third; then valid=0.
- Single bit and zero mask: imm8=8'b0000_0001 -> one micro-op (0, base), last=1, stall never asserted. imm8=0 -> no valid, no stall, busy stays 0.
- Full mask with wrap: SM, imm8=FF, base=0xFFFE -> LM_reg 0..7, addresses FFFE, FFFF, 0000 ... 0005; is_store_o=1 throughout; 8 valid cycles.
- Flush mid-op: imm8=FF, assert flush during the 3rd RUN cycle -> next cycle valid=0, busy=0. A new start (imm8=8'b0000_0011) two cycles later sequences R0, R1 from its own base.
- Back-to-back: second start (imm8=8'b1000_0000, base=0x10) presented on the last cycle of a prior instruction -> next cycle valid=1, LM_reg=7, mem_addr=0x10, no idle gap.

Source files
------------

// File: rtl/lm_sm_sequencer_if.sv
// ----------------------------------------------------------------------------
// lm_sm_sequencer_if
// Bundle between the decode stage (master) and the LM/SM sequencer (slave).
//   start      : decode presents a valid LM/SM this cycle
//   is_store   : 1 = SM, 0 = LM, sampled with start
//   imm8       : register mask, bit i selects Ri
//   base_addr  : start address (contents of RA), sampled with start
//   flush      : pipeline flush from branch/jump resolution
//   valid      : micro-op outputs valid this cycle
//   LM_reg     : register index of the current micro-op
//   mem_addr   : word address of the current micro-op
//   is_store_o : latched is_store for the current micro-op
//   last       : current micro-op is the final one of the instruction
//   stall      : hold PC/IF/ID this cycle (combinational)
//   busy       : sequencer is expanding an instruction
// ----------------------------------------------------------------------------
interface lm_sm_sequencer_if #(
    parameter int ADDR_W = 16
);
    logic              start;
    logic              is_store;
    logic [7:0]        imm8;
    logic [ADDR_W-1:0] base_addr;
    logic              flush;

    logic              valid;
    logic [2:0]        LM_reg;
    logic [ADDR_W-1:0] mem_addr;
    logic              is_store_o;
    logic              last;
    logic              stall;
    logic              busy;

    modport master (
        output start, is_store, imm8, base_addr, flush,
        input  valid, LM_reg, mem_addr, is_store_o, last, stall, busy
    );

    modport slave (
        input  start, is_store, imm8, base_addr, flush,
        output valid, LM_reg, mem_addr, is_store_o, last, stall, busy
    );
endinterface

// File: rtl/lm_sm_sequencer.sv
// ----------------------------------------------------------------------------
// lm_sm_sequencer
// Decode-stage sequencer for Load/Store Multiple. Expands the 8-bit register
// mask into one micro-op per set bit, ascending register order, with a word
// address that increments by ADDR_STEP per transfer (modulo 2^ADDR_W).
// Ports:
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : lm_sm_sequencer_if.slave (request in, micro-op/stall out)
// All outputs except stall are registered.
// ----------------------------------------------------------------------------
module lm_sm_sequencer #(
    parameter int ADDR_W    = 16,
    parameter int ADDR_STEP = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    lm_sm_sequencer_if.slave     bus
);

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [7:0]        r_mask;       // bits still to be issued after current op
    logic              r_valid;
    logic [2:0]        r_lm_reg;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_is_store;
    logic              r_last;
    logic              w_stall;

    // Index of the lowest set bit; scanning downward leaves the lowest one.
    function automatic logic [2:0] f_low_idx(input logic [7:0] m);
        logic [2:0] idx;
        idx = '0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    logic [7:0] w_imm_rest;   // imm8 with its lowest set bit cleared
    logic [7:0] w_mask_rest;  // remaining mask with its lowest set bit cleared
    logic       w_can_take;   // sequencer free to accept (idle or final op)
    logic       w_accept;

    assign w_imm_rest  = bus.imm8 & (bus.imm8 - 8'd1);
    assign w_mask_rest = r_mask & (r_mask - 8'd1);
    assign w_can_take  = (r_state == S_IDLE) || r_last;
    // Zero mask is a NOP; flush wins over a new start.
    assign w_accept    = w_can_take && bus.start && (bus.imm8 != 8'd0) && !bus.flush;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        if (bus.flush) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) w_state_nxt = S_RUN;
                S_RUN:  if (r_last)   w_state_nxt = w_accept ? S_RUN : S_IDLE;
                default:              w_state_nxt = S_IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    // Stall while more ops remain, or when a new multi-op instruction is
    // accepted (it will occupy decode for more than one cycle).
    always_comb begin
        w_stall = 1'b0;
        if (rst_n && !bus.flush) begin
            if ((r_state == S_RUN) && !r_last)
                w_stall = 1'b1;
            else if (w_can_take && bus.start && (w_imm_rest != 8'd0))
                w_stall = 1'b1;
        end
    end

    // ---------------- micro-op datapath ----------------
    // LM_reg/mem_addr intentionally hold while valid=0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_lm_reg   <= '0;
            r_mem_addr <= '0;
            r_is_store <= 1'b0;
            r_last     <= 1'b0;
            r_mask     <= '0;
        end else if (bus.flush) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_mask  <= '0;
        end else if (w_accept) begin
            r_valid    <= 1'b1;
            r_lm_reg   <= f_low_idx(bus.imm8);
            r_mem_addr <= bus.base_addr;
            r_is_store <= bus.is_store;
            r_mask     <= w_imm_rest;
            r_last     <= (w_imm_rest == 8'd0);
        end else if ((r_state == S_RUN) && !r_last) begin
            r_lm_reg   <= f_low_idx(r_mask);
            r_mem_addr <= r_mem_addr + ADDR_W'(ADDR_STEP);
            r_mask     <= w_mask_rest;
            r_last     <= (w_mask_rest == 8'd0);
        end else if (r_state == S_RUN) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end
    end

    assign bus.valid      = r_valid;
    assign bus.LM_reg     = r_lm_reg;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.is_store_o = r_is_store;
    assign bus.last       = r_last;
    assign bus.stall      = w_stall;
    assign bus.busy       = (r_state == S_RUN);

endmodule
